// File: rtl/ecc_104_err_log.sv
// ecc_104_err_log: registered error-logging stage behind the 104-bit ECC decoder.
// It pipelines the corrected data by one cycle and flags poisoned words.
// It keeps saturating event counts and sticky bits, captures the first error,
// and drives a level interrupt.
module ecc_104_err_log #(
  parameter int unsigned             DATA_WIDTH  = 104,
  parameter int unsigned             ADDR_WIDTH  = 8,
  parameter int unsigned             CNT_WIDTH   = 16,
  parameter logic [CNT_WIDTH-1:0]    SBIT_THRESH = CNT_WIDTH'(8)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_vld,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  sbit_err,
  input  logic                  dbit_err,
  input  logic                  ecc_fault,
  input  logic                  err_clr,
  input  logic                  int_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_vld,
  output logic                  data_poison,
  output logic [CNT_WIDTH-1:0]  sbit_cnt,
  output logic [CNT_WIDTH-1:0]  dbit_cnt,
  output logic [CNT_WIDTH-1:0]  fault_cnt,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [1:0]            first_err_type,
  output logic [2:0]            err_sticky,
  output logic                  err_int
);

  localparam logic [1:0] TYPE_NONE  = 2'b00;
  localparam logic [1:0] TYPE_SBIT  = 2'b01;
  localparam logic [1:0] TYPE_DBIT  = 2'b10;
  localparam logic [1:0] TYPE_FAULT = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } cap_state_e;

  // Saturating increment: never wraps past all-ones.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c,
                                                   input logic              hit);
    return (hit && (c != {CNT_WIDTH{1'b1}})) ? c + CNT_WIDTH'(1) : c;
  endfunction

  logic [DATA_WIDTH-1:0] data_q;
  logic                  vld_q;
  logic                  poison_q;
  logic [CNT_WIDTH-1:0]  sbit_cnt_q,  sbit_cnt_d;
  logic [CNT_WIDTH-1:0]  dbit_cnt_q,  dbit_cnt_d;
  logic [CNT_WIDTH-1:0]  fault_cnt_q, fault_cnt_d;
  logic [2:0]            sticky_q,    sticky_d;
  logic                  int_q,       int_d;
  logic [ADDR_WIDTH-1:0] cap_addr_q;
  logic [1:0]            cap_type_q;
  cap_state_e            state_q;

  logic                  s_hit_c, d_hit_c, f_hit_c, any_hit_c;
  logic [1:0]            hit_type_c;

  // Flags only count when the decoder output is valid.
  assign s_hit_c   = rd_vld & sbit_err;
  assign d_hit_c   = rd_vld & dbit_err;
  assign f_hit_c   = rd_vld & ecc_fault;
  assign any_hit_c = s_hit_c | d_hit_c | f_hit_c;

  // Capture type priority: fault over dbit over sbit.
  always_comb begin
    hit_type_c = TYPE_NONE;
    if (f_hit_c)      hit_type_c = TYPE_FAULT;
    else if (d_hit_c) hit_type_c = TYPE_DBIT;
    else if (s_hit_c) hit_type_c = TYPE_SBIT;
  end

  // Next counters/sticky: a clear zeroes the base, then this cycle's event is added.
  always_comb begin
    sbit_cnt_d  = err_clr ? '0 : sbit_cnt_q;
    dbit_cnt_d  = err_clr ? '0 : dbit_cnt_q;
    fault_cnt_d = err_clr ? '0 : fault_cnt_q;
    sticky_d    = err_clr ? 3'b000 : sticky_q;

    sbit_cnt_d  = sat_inc(sbit_cnt_d,  s_hit_c);
    dbit_cnt_d  = sat_inc(dbit_cnt_d,  d_hit_c);
    fault_cnt_d = sat_inc(fault_cnt_d, f_hit_c);
    sticky_d    = sticky_d | {f_hit_c, d_hit_c, s_hit_c};

    int_d = int_en & (sticky_d[2] | sticky_d[1] | (sbit_cnt_d >= SBIT_THRESH));
  end

  // Data pipeline: data holds when idle, valid/poison follow every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q   <= '0;
      vld_q    <= 1'b0;
      poison_q <= 1'b0;
    end else begin
      if (rd_vld) data_q <= data_in;
      vld_q    <= rd_vld;
      poison_q <= d_hit_c | f_hit_c;
    end
  end

  // Event counters, sticky bits and interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sbit_cnt_q  <= '0;
      dbit_cnt_q  <= '0;
      fault_cnt_q <= '0;
      sticky_q    <= 3'b000;
      int_q       <= 1'b0;
    end else begin
      sbit_cnt_q  <= sbit_cnt_d;
      dbit_cnt_q  <= dbit_cnt_d;
      fault_cnt_q <= fault_cnt_d;
      sticky_q    <= sticky_d;
      int_q       <= int_d;
    end
  end

  // First-error capture FSM; a clear in the same cycle as an error re-arms and captures it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cap_addr_q <= '0;
      cap_type_q <= TYPE_NONE;
    end else begin
      if (err_clr) begin
        state_q    <= IDLE;
        cap_addr_q <= '0;
        cap_type_q <= TYPE_NONE;
      end
      if (any_hit_c && (err_clr || (state_q == IDLE))) begin
        state_q    <= HELD;
        cap_addr_q <= rd_addr;
        cap_type_q <= hit_type_c;
      end
    end
  end

  assign data_out       = data_q;
  assign data_vld       = vld_q;
  assign data_poison    = poison_q;
  assign sbit_cnt       = sbit_cnt_q;
  assign dbit_cnt       = dbit_cnt_q;
  assign fault_cnt      = fault_cnt_q;
  assign first_err_addr = cap_addr_q;
  assign first_err_type = cap_type_q;
  assign err_sticky     = sticky_q;
  assign err_int        = int_q;

endmodule

// File: tb/tb_ecc_104_err_log.sv
// Directed self-checking bench for ecc_104_err_log (4-bit counters, threshold 8).
module tb_ecc_104_err_log;

  localparam int unsigned DW = 104;
  localparam int unsigned AW = 8;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_vld;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] data_in;
  logic          sbit_err, dbit_err, ecc_fault, err_clr, int_en;
  logic [DW-1:0] data_out;
  logic          data_vld, data_poison;
  logic [CW-1:0] sbit_cnt, dbit_cnt, fault_cnt;
  logic [AW-1:0] first_err_addr;
  logic [1:0]    first_err_type;
  logic [2:0]    err_sticky;
  logic          err_int;

  int n_tests = 0;
  int n_fail  = 0;

  ecc_104_err_log #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .CNT_WIDTH  (CW),
    .SBIT_THRESH(4'd8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rd_vld        (rd_vld),
    .rd_addr       (rd_addr),
    .data_in       (data_in),
    .sbit_err      (sbit_err),
    .dbit_err      (dbit_err),
    .ecc_fault     (ecc_fault),
    .err_clr       (err_clr),
    .int_en        (int_en),
    .data_out      (data_out),
    .data_vld      (data_vld),
    .data_poison   (data_poison),
    .sbit_cnt      (sbit_cnt),
    .dbit_cnt      (dbit_cnt),
    .fault_cnt     (fault_cnt),
    .first_err_addr(first_err_addr),
    .first_err_type(first_err_type),
    .err_sticky    (err_sticky),
    .err_int       (err_int)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one word for one clock, then sample 1 time unit after the edge.
  task automatic cyc(input logic v, input logic [AW-1:0] a,
                     input logic s, input logic d, input logic f, input logic clr);
    rd_vld = v; rd_addr = a; sbit_err = s; dbit_err = d; ecc_fault = f; err_clr = clr;
    @(posedge clk); #1;
    rd_vld = 1'b0; sbit_err = 1'b0; dbit_err = 1'b0; ecc_fault = 1'b0; err_clr = 1'b0;
  endtask

  // Check all logging outputs at once.
  task automatic chk_log(input string tag, input logic [CW-1:0] s, input logic [CW-1:0] d,
                         input logic [CW-1:0] f, input logic [AW-1:0] a,
                         input logic [1:0] t, input logic [2:0] st);
    chk({tag, ".sbit_cnt"},  128'(sbit_cnt),       128'(s));
    chk({tag, ".dbit_cnt"},  128'(dbit_cnt),       128'(d));
    chk({tag, ".fault_cnt"}, 128'(fault_cnt),      128'(f));
    chk({tag, ".addr"},      128'(first_err_addr), 128'(a));
    chk({tag, ".type"},      128'(first_err_type), 128'(t));
    chk({tag, ".sticky"},    128'(err_sticky),     128'(st));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] pat_a5;
    logic [DW-1:0] pat_3c;
    int            exp_cnt;
    pat_a5 = {13{8'hA5}};
    pat_3c = {13{8'h3C}};

    rst = 1'b1; rd_vld = 1'b0; rd_addr = '0; data_in = pat_3c;
    sbit_err = 1'b0; dbit_err = 1'b0; ecc_fault = 1'b0; err_clr = 1'b0; int_en = 1'b1;

    // Reset with rd_vld and flags toggling: nothing may leak through.
    for (int i = 0; i < 4; i++) begin
      rd_vld = i[0]; sbit_err = 1'b1; dbit_err = i[1]; rd_addr = 8'(i);
      @(posedge clk); #1;
    end
    chk("rst.data_out", 128'(data_out), 128'(0));
    chk("rst.data_vld", 128'(data_vld), 128'(0));
    chk("rst.poison",   128'(data_poison), 128'(0));
    chk("rst.err_int",  128'(err_int), 128'(0));
    chk_log("rst", 4'd0, 4'd0, 4'd0, 8'h00, 2'b00, 3'b000);
    rd_vld = 1'b0; sbit_err = 1'b0; dbit_err = 1'b0;
    rst = 1'b0; int_en = 1'b0;
    @(posedge clk); #1;

    // Clean word: one-cycle latency, no counting.
    data_in = pat_a5;
    cyc(1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("clean.data_vld", 128'(data_vld), 128'(1));
    chk("clean.data_out", 128'(data_out), 128'(pat_a5));
    chk("clean.poison",   128'(data_poison), 128'(0));
    chk_log("clean", 4'd0, 4'd0, 4'd0, 8'h00, 2'b00, 3'b000);
    data_in = pat_3c;
    cyc(1'b0, 8'h11, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("idle.data_vld", 128'(data_vld), 128'(0));
    chk("idle.data_hold", 128'(data_out), 128'(pat_a5));
    chk("idle.poison", 128'(data_poison), 128'(0));
    chk_log("idle", 4'd0, 4'd0, 4'd0, 8'h00, 2'b00, 3'b000);

    // First-error capture: sbit then dbit, capture stays on the sbit.
    int_en = 1'b1;
    cyc(1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_log("cap1", 4'd1, 4'd0, 4'd0, 8'h03, 2'b01, 3'b001);
    chk("cap1.err_int", 128'(err_int), 128'(0));
    chk("cap1.data_out", 128'(data_out), 128'(pat_3c));
    cyc(1'b1, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0);
    chk_log("cap2", 4'd1, 4'd1, 4'd0, 8'h03, 2'b01, 3'b011);
    chk("cap2.err_int", 128'(err_int), 128'(1));
    chk("cap2.poison",  128'(data_poison), 128'(1));

    // Standalone clear drops everything, including the interrupt.
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_log("clr", 4'd0, 4'd0, 4'd0, 8'h00, 2'b00, 3'b000);
    chk("clr.err_int", 128'(err_int), 128'(0));

    // All three flags in one word: fault wins capture, poison for one cycle.
    cyc(1'b1, 8'h20, 1'b1, 1'b1, 1'b1, 1'b0);
    chk_log("all3", 4'd1, 4'd1, 4'd1, 8'h20, 2'b11, 3'b111);
    chk("all3.poison", 128'(data_poison), 128'(1));
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("all3.poison_off", 128'(data_poison), 128'(0));

    // Saturation and threshold: 20 sbit words after a clear.
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 20; i++) begin
      cyc(1'b1, 8'(8'h40 + i), 1'b1, 1'b0, 1'b0, 1'b0);
      exp_cnt = (i > 15) ? 15 : i;
      chk($sformatf("sat.cnt%0d", i), 128'(sbit_cnt), 128'(exp_cnt));
      chk($sformatf("sat.int%0d", i), 128'(err_int), 128'(i >= 8));
    end
    chk("sat.addr", 128'(first_err_addr), 128'(8'h41));
    int_en = 1'b0;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("inten_off.err_int", 128'(err_int), 128'(0));
    chk("inten_off.cnt", 128'(sbit_cnt), 128'(15));

    // Clear collides with a fault while HELD: new fault is recorded alone.
    cyc(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1);
    chk_log("coll", 4'd0, 4'd0, 4'd1, 8'h55, 2'b11, 3'b100);

    // Async reset mid-burst: outputs drop without a clock edge.
    int_en = 1'b1;
    rd_vld = 1'b1; sbit_err = 1'b1; dbit_err = 1'b1; rd_addr = 8'h66;
    @(posedge clk); @(posedge clk); #3;
    chk("pre_arst.data_vld", 128'(data_vld), 128'(1));
    rst = 1'b1;
    #1;
    chk("arst.data_vld", 128'(data_vld), 128'(0));
    chk("arst.err_int",  128'(err_int), 128'(0));
    chk("arst.data_out", 128'(data_out), 128'(0));
    chk_log("arst", 4'd0, 4'd0, 4'd0, 8'h00, 2'b00, 3'b000);
    @(posedge clk); #1;
    rst = 1'b0;
    rd_vld = 1'b0; sbit_err = 1'b0; dbit_err = 1'b0;
    cyc(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_log("post_arst", 4'd1, 4'd0, 4'd0, 8'h77, 2'b01, 3'b001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ecc_104_err_log.md
# ecc_104_err_log

Registered error-logging stage placed directly downstream of the 104-bit ECC fault-detect decoder on the FIFO read path. Pipelines the corrected read data by one cycle, tags it with a poison flag, and keeps saturating counts of single-bit, double-bit and detector-fault events. Also captures the address and type of the first error since the last clear, and raises a level interrupt for software.

## Interface
Parameters:
- DATA_WIDTH, 104, width of corrected read data
- ADDR_WIDTH, 8, width of read address carried alongside data
- CNT_WIDTH, 16, width of each saturating event counter
- SBIT_THRESH, 16'd8, sbit count at or above which the interrupt fires

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- rd_vld  in  1  decoder outputs valid this cycle
- rd_addr  in  ADDR_WIDTH  address of the word being decoded
- data_in  in  DATA_WIDTH  decoder data_out
- sbit_err  in  1  decoder single-bit (corrected) flag
- dbit_err  in  1  decoder double-bit (uncorrectable) flag
- ecc_fault  in  1  decoder duplicate-compare mismatch flag
- err_clr  in  1  one-cycle pulse; clears counters, capture, sticky bits
- int_en  in  1  interrupt enable
- data_out  out  DATA_WIDTH  registered data
- data_vld  out  1  registered rd_vld
- data_poison  out  1  registered (dbit_err|ecc_fault)&rd_vld
- sbit_cnt, dbit_cnt, fault_cnt  out  CNT_WIDTH each  saturating event counts
- first_err_addr  out  ADDR_WIDTH  address of first captured error
- first_err_type  out  2  00 none, 01 sbit, 10 dbit, 11 fault
- err_sticky  out  3  {fault, dbit, sbit} seen since clear
- err_int  out  1  registered interrupt

## Operation
- Flags are sampled only when rd_vld=1; with rd_vld=0 the flags are ignored entirely.
- Data path: data_out loads data_in only when rd_vld=1 and holds otherwise. data_vld and data_poison are updated every cycle.
- Counters: each flag increments its own counter independently. One word may bump several counters. Each counter saturates at all-ones and never wraps.
- Sticky: the err_sticky bit for each flag is set when that flag is sampled.
- Capture FSM with two states, IDLE and HELD:
  - IDLE to HELD on a sampled word with any flag set. This latches rd_addr and the type, with priority fault > dbit > sbit.
  - HELD holds the captured values until err_clr, then returns to IDLE.
  - Later errors while HELD do not overwrite the capture.
- err_clr takes effect at the next edge and zeroes the counters, sticky bits, capture and FSM. It does not affect the data path.
- err_clr together with a sampled error in the same cycle: clear applies first, then the new event is recorded.
  - Result: the relevant counter = 1, sticky set, FSM goes to HELD with the new address and type.
- Interrupt: err_int_next = int_en & (err_sticky[2] | err_sticky[1] | sbit_cnt >= SBIT_THRESH). The terms use the post-update values.

## Timing
- Latency is 1 cycle from inputs to data_out, data_vld, data_poison, counters, sticky and capture.
- err_int is registered from the post-update state, so it asserts in the same cycle the triggering count or sticky bit becomes visible.
- err_int deasserts the cycle after err_clr, or the cycle after int_en falls.
- Reset values:
  - all outputs 0
  - first_err_type = 00
  - FSM in IDLE
  - data_out = 0
- Reset is asynchronous assert and synchronous-safe deassert. Reset asserted mid-stream discards any in-flight word, and data_vld reads 0 immediately.
- No back-pressure: the block accepts a word every cycle.

## Test plan
- **Reset and idle:** assert rst with rd_vld toggling -> all outputs 0, first_err_type=00. Release reset, send a clean word with data 0xA5 repeated and addr 0x10 -> one cycle later data_vld=1, data_out matches, counters stay 0.
- **First-error capture:** send sbit at addr 0x03, then dbit at 0x07 -> sbit_cnt=1, dbit_cnt=1, first_err_addr=0x03, type=01, err_sticky=3'b011. With int_en=1, err_int=1 on the cycle dbit_cnt becomes 1.
- **Priority and poison:** send one word with sbit, dbit and fault all set at addr 0x20 -> all three counters=1, type=11, data_poison=1 for exactly one cycle.
- **Saturation and threshold:** with CNT_WIDTH=4 and SBIT_THRESH=8, send 20 sbit words -> err_int rises with the 8th, sbit_cnt holds at 15, no wrap.
- **Clear collision:** pulse err_clr in the same cycle as a fault at addr 0x55 -> next cycle fault_cnt=1, other counters 0, first_err_addr=0x55, type=11.
- **Async reset mid-burst:** assert rst between edges during a burst -> outputs reach 0 without waiting for a clock edge. After release, counting restarts from 0.
